// File: rtl/utopia_rx_arbiter.sv
// ---------------------------------------------------------------------------
// utopia_rx_arbiter
//
// Round-robin cell arbiter that shares the forwarding datapath among NUM_RX
// Utopia Rx ports. One requesting, enabled port is granted at a time, and the
// grant is held for a whole cell of CELL_BYTES bytes. The granted port's byte
// stream is multiplexed onto a single valid/ready output that carries SOP/EOP
// markers. The arbiter sits between the per-port Rx receivers and the cell
// lookup/forwarding stage. The port enable mask comes from CPU configuration.
//
// Ports
//   i_clk          system clock
//   i_rst          asynchronous reset, active-high
//   i_req          per-port "complete cell ready", held until its EOP moves
//   i_port_en      per-port enable mask; disabled ports are never granted
//   i_in_data      byte from port i at bits [8i+7:8i]
//   i_in_valid     per-port byte valid
//   o_in_ready     per-port byte accept (only the granted port can see it)
//   o_grant        registered one-hot grant, zero while idle
//   o_busy         cell transfer in progress
//   o_out_data     muxed byte towards the forwarding stage
//   o_out_valid    o_out_data valid
//   i_out_ready    downstream accepts the byte
//   o_out_sop      current byte is cell byte 0
//   o_out_eop      current byte is cell byte CELL_BYTES-1
//   o_out_port     registered index of the granted port
//   o_cell_count   cells forwarded since reset (wraps)
// ---------------------------------------------------------------------------
module utopia_rx_arbiter #(
  parameter int NUM_RX     = 4,
  parameter int CELL_BYTES = 53,
  parameter int PW         = $clog2(NUM_RX)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [NUM_RX-1:0]    i_req,
  input  logic [NUM_RX-1:0]    i_port_en,
  input  logic [NUM_RX*8-1:0]  i_in_data,
  input  logic [NUM_RX-1:0]    i_in_valid,
  output logic [NUM_RX-1:0]    o_in_ready,
  output logic [NUM_RX-1:0]    o_grant,
  output logic                 o_busy,
  output logic [7:0]           o_out_data,
  output logic                 o_out_valid,
  input  logic                 i_out_ready,
  output logic                 o_out_sop,
  output logic                 o_out_eop,
  output logic [PW-1:0]        o_out_port,
  output logic [15:0]          o_cell_count
);

  localparam int CW = (CELL_BYTES > 2) ? $clog2(CELL_BYTES) : 1;
  localparam logic [CW-1:0] LAST_BYTE = CW'(CELL_BYTES - 1);
  localparam logic [PW-1:0] LAST_PORT = PW'(NUM_RX - 1);

  typedef enum logic {
    ST_IDLE,
    ST_XFER
  } state_t;

  state_t              r_state;
  logic [NUM_RX-1:0]   r_grant;
  logic [PW-1:0]       r_outPort;
  logic [CW-1:0]       r_cnt;
  logic [PW-1:0]       r_last;
  logic [15:0]         r_cellCount;

  logic [NUM_RX-1:0]   w_eligible;
  logic                w_selFound;
  logic [PW-1:0]       w_selPort;
  logic [NUM_RX-1:0]   w_selOneHot;
  logic                w_inXfer;
  logic                w_inValidG;
  logic                w_xfer;
  logic                w_lastByte;

  // A port competes only while it both requests and is enabled.
  assign w_eligible = i_req & i_port_en;

  // Round-robin search that starts one past the last served port and wraps.
  // The first eligible port wins. The pointer moves only when a cell ends, so
  // a port that is alone in requesting is found again on its own turn.
  always_comb begin
    w_selFound = 1'b0;
    w_selPort  = '0;
    for (int k = 1; k <= NUM_RX; k++) begin
      if (!w_selFound && w_eligible[(int'(r_last) + k) % NUM_RX]) begin
        w_selFound = 1'b1;
        w_selPort  = PW'((int'(r_last) + k) % NUM_RX);
      end
    end
  end

  // One-hot version of the winner, loaded into the grant register.
  always_comb begin
    w_selOneHot = '0;
    w_selOneHot[w_selPort] = 1'b1;
  end

  // Datapath steering. Everything is gated by the XFER state, so in IDLE (and
  // while reset forces IDLE) the handshake outputs stay low whatever the
  // inputs do.
  assign w_inXfer    = (r_state == ST_XFER);
  assign w_inValidG  = i_in_valid[r_outPort];
  assign w_xfer      = w_inXfer && w_inValidG && i_out_ready;
  assign w_lastByte  = (r_cnt == LAST_BYTE);

  assign o_out_data  = i_in_data[{r_outPort, 3'b000} +: 8];
  assign o_out_valid = w_inXfer && w_inValidG;
  assign o_out_sop   = w_inXfer && (r_cnt == '0);
  assign o_out_eop   = w_inXfer && w_lastByte;
  assign o_busy      = w_inXfer;

  // Only the granted port sees ready, and it simply mirrors downstream ready.
  // A byte therefore moves on exactly the cycles that the output side
  // accepts it.
  always_comb begin
    o_in_ready = '0;
    if (w_inXfer) begin
      o_in_ready[r_outPort] = i_out_ready;
    end
  end

  // Arbitration FSM and its registered outputs. The grant is taken in IDLE.
  // In XFER the byte counter advances on each accepted byte. The EOP byte
  // releases the grant, records the served port for the round-robin pointer
  // and counts the cell. Reset drops any partial cell without counting it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_grant     <= '0;
      r_outPort   <= '0;
      r_cnt       <= '0;
      r_last      <= LAST_PORT;
      r_cellCount <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_selFound) begin
            r_grant   <= w_selOneHot;
            r_outPort <= w_selPort;
            r_cnt     <= '0;
            r_state   <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (w_xfer) begin
            if (w_lastByte) begin
              r_cnt       <= '0;
              r_last      <= r_outPort;
              r_cellCount <= r_cellCount + 16'd1;
              r_grant     <= '0;
              r_state     <= ST_IDLE;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_grant <= '0;
        end
      endcase
    end
  end

  assign o_grant      = r_grant;
  assign o_out_port   = r_outPort;
  assign o_cell_count = r_cellCount;

endmodule

// File: tb/tb_utopia_rx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_utopia_rx_arbiter
//
// Directed bench for utopia_rx_arbiter. Each port has a byte source that
// counts its own bytes and cells. Queuing a cell raises the port's request
// and pushes the 53 expected output bytes onto a scoreboard. Those bytes are
// ordered by the round-robin order that the test expects. The output monitor
// pops one entry per accepted output byte and compares port, SOP, EOP and
// data.
// ---------------------------------------------------------------------------
module tb_utopia_rx_arbiter;

  localparam int NUM_RX     = 4;
  localparam int CELL_BYTES = 53;
  localparam int PW         = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NUM_RX-1:0]    i_req;
  logic [NUM_RX-1:0]    i_port_en;
  logic [NUM_RX*8-1:0]  i_in_data;
  logic [NUM_RX-1:0]    i_in_valid;
  logic [NUM_RX-1:0]    o_in_ready;
  logic [NUM_RX-1:0]    o_grant;
  logic                 o_busy;
  logic [7:0]           o_out_data;
  logic                 o_out_valid;
  logic                 i_out_ready;
  logic                 o_out_sop;
  logic                 o_out_eop;
  logic [PW-1:0]        o_out_port;
  logic [15:0]          o_cell_count;

  utopia_rx_arbiter #(
    .NUM_RX     (NUM_RX),
    .CELL_BYTES (CELL_BYTES),
    .PW         (PW)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req        (i_req),
    .i_port_en    (i_port_en),
    .i_in_data    (i_in_data),
    .i_in_valid   (i_in_valid),
    .o_in_ready   (o_in_ready),
    .o_grant      (o_grant),
    .o_busy       (o_busy),
    .o_out_data   (o_out_data),
    .o_out_valid  (o_out_valid),
    .i_out_ready  (i_out_ready),
    .o_out_sop    (o_out_sop),
    .o_out_eop    (o_out_eop),
    .o_out_port   (o_out_port),
    .o_cell_count (o_cell_count)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  typedef struct packed {
    logic [PW-1:0] port;
    logic          sop;
    logic          eop;
    logic [7:0]    data;
  } expByte_t;

  expByte_t          expQ[$];
  int                errors = 0;
  int                checks = 0;
  int                bytePos   [NUM_RX];
  int                cellSeq   [NUM_RX];
  int                cellsLeft [NUM_RX];
  int                expSeq    [NUM_RX];
  logic [NUM_RX-1:0] portEn;
  logic [NUM_RX-1:0] hsMask;
  logic [NUM_RX-1:0] forbiddenMask;
  bit                stallMode;
  bit                eopPopped;
  bit                sawForbiddenReady;
  int                cyc;

  // Byte pattern seen on port p, cell number seq, byte b.
  function automatic logic [7:0] byteFor(int p, int seq, int b);
    return 8'(p * 61 + seq * 17 + b * 5 + 1);
  endfunction

  // Single comparison point: counts the check and reports any failure.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Drive every DUT input from the bench source state.
  task automatic applyStimulus();
    for (int p = 0; p < NUM_RX; p++) begin
      i_req[p]          = (cellsLeft[p] > 0);
      i_in_data[p*8 +: 8] = byteFor(p, cellSeq[p], bytePos[p]);
      i_in_valid[p]     = (cellsLeft[p] > 0) && (!stallMode || (cyc % 3) != 1);
    end
    i_port_en   = portEn;
    i_out_ready = !stallMode || ((cyc % 2) == 0);
  endtask

  // Request one more cell on port p and expect its 53 bytes next in order.
  task automatic queueCell(input int p);
    expByte_t e;
    for (int b = 0; b < CELL_BYTES; b++) begin
      e.port = PW'(p);
      e.sop  = (b == 0);
      e.eop  = (b == CELL_BYTES - 1);
      e.data = byteFor(p, expSeq[p], b);
      expQ.push_back(e);
    end
    expSeq[p]++;
    cellsLeft[p]++;
  endtask

  task automatic clearBench();
    for (int p = 0; p < NUM_RX; p++) begin
      bytePos[p]   = 0;
      cellSeq[p]   = 0;
      cellsLeft[p] = 0;
      expSeq[p]    = 0;
    end
    expQ.delete();
    portEn            = '1;
    hsMask            = '0;
    forbiddenMask     = '0;
    stallMode         = 1'b0;
    eopPopped         = 1'b0;
    sawForbiddenReady = 1'b0;
    cyc               = 0;
  endtask

  task automatic resetDut();
    rst = 1'b1;
    clearBench();
    applyStimulus();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Mid-cycle monitor: record source handshakes and score accepted bytes.
  task automatic sampleOutputs();
    expByte_t e;
    hsMask = i_in_valid & o_in_ready;
    if (o_out_valid && i_out_ready) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_byte", 32'(o_out_valid), 32'd0);
      end else begin
        e = expQ.pop_front();
        checkOutput("byte", 32'({o_out_port, o_out_sop, o_out_eop, o_out_data}), 32'(e));
        if (e.eop) eopPopped = 1'b1;
      end
    end
    if (stallMode && !i_out_ready)
      checkOutput("ready_while_stalled", 32'(o_in_ready), 32'd0);
    if ((o_in_ready & forbiddenMask) != '0)
      sawForbiddenReady = 1'b1;
  endtask

  // One clock: sample at negedge, then advance the sources after the edge.
  task automatic stepCycle();
    @(negedge clk);
    sampleOutputs();
    @(posedge clk);
    #1;
    cyc++;
    for (int p = 0; p < NUM_RX; p++) begin
      if (hsMask[p]) begin
        if (bytePos[p] == CELL_BYTES - 1) begin
          bytePos[p] = 0;
          cellSeq[p]++;
          if (cellsLeft[p] > 0) cellsLeft[p]--;
        end else begin
          bytePos[p]++;
        end
      end
    end
    if (eopPopped) begin
      eopPopped = 1'b0;
      checkOutput("idle_after_eop", 32'({o_busy, o_grant}), 32'd0);
    end
    applyStimulus();
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (expQ.size() > 0 && n < budget) begin
      stepCycle();
      n++;
    end
    if (expQ.size() > 0)
      checkOutput("drain_timeout", 32'(expQ.size()), 32'd0);
  endtask

  task automatic runToByte(input int p, input int target, input string tag);
    int n;
    n = 0;
    while (bytePos[p] != target && n < 300) begin
      stepCycle();
      n++;
    end
    checkOutput(tag, 32'(bytePos[p]), 32'(target));
  endtask

  initial begin
    rst = 1'b1;
    clearBench();
    applyStimulus();
    #1;
    checkOutput("reset_grant",     32'(o_grant),      32'd0);
    checkOutput("reset_busy",      32'(o_busy),       32'd0);
    checkOutput("reset_handshake", 32'({o_out_valid, o_out_sop, o_out_eop, o_in_ready}), 32'd0);
    checkOutput("reset_out_port",  32'(o_out_port),   32'd0);
    checkOutput("reset_cells",     32'(o_cell_count), 32'd0);

    // Test 1: single cell on port 0, grant one edge after request
    $display("[TB] test 1: single cell port 0");
    resetDut();
    queueCell(0);
    applyStimulus();
    checkOutput("t1_grant_before_edge", 32'(o_grant), 32'd0);
    stepCycle();
    checkOutput("t1_grant",    32'(o_grant),    32'b0001);
    checkOutput("t1_busy",     32'(o_busy),     32'd1);
    checkOutput("t1_out_port", 32'(o_out_port), 32'd0);
    drain(200);
    repeat (3) stepCycle();
    checkOutput("t1_cells", 32'(o_cell_count), 32'd1);

    // Test 2: all ports requesting, strict 0,1,2,3 rotation twice
    $display("[TB] test 2: four-way rotation");
    resetDut();
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < NUM_RX; p++)
        queueCell(p);
    applyStimulus();
    drain(1000);
    checkOutput("t2_cells", 32'(o_cell_count), 32'd8);

    // Test 3: ports 0 and 2 disabled, only 1 and 3 alternate
    $display("[TB] test 3: enable mask 1010");
    resetDut();
    portEn        = 4'b1010;
    forbiddenMask = 4'b0101;
    cellsLeft[0]  = 2;
    cellsLeft[2]  = 2;
    queueCell(1); queueCell(3); queueCell(1); queueCell(3);
    applyStimulus();
    drain(1000);
    repeat (4) stepCycle();
    checkOutput("t3_disabled_ready", 32'(sawForbiddenReady), 32'd0);
    checkOutput("t3_cells",          32'(o_cell_count),     32'd4);
    checkOutput("t3_no_grant",       32'(o_grant),          32'd0);

    // Test 4: port 2 with toggling out_ready and in_valid gaps
    $display("[TB] test 4: stalls on port 2");
    resetDut();
    stallMode = 1'b1;
    queueCell(2);
    applyStimulus();
    drain(600);
    repeat (4) stepCycle();
    checkOutput("t4_cells", 32'(o_cell_count), 32'd1);
    stallMode = 1'b0;

    // Test 5: port_en dropped mid-cell, cell still completes
    $display("[TB] test 5: disable granted port at byte 20");
    resetDut();
    queueCell(1);
    cellsLeft[1]++;
    applyStimulus();
    runToByte(1, 20, "t5_reach_byte20");
    portEn[1] = 1'b0;
    applyStimulus();
    drain(200);
    repeat (4) stepCycle();
    checkOutput("t5_cells",    32'(o_cell_count), 32'd1);
    checkOutput("t5_no_grant", 32'({o_busy, o_grant}), 32'd0);

    // Test 6: reset in the middle of a cell
    $display("[TB] test 6: reset at byte 30");
    resetDut();
    queueCell(1);
    applyStimulus();
    runToByte(1, 30, "t6_reach_byte30");
    #2;
    rst = 1'b1;
    #1;
    checkOutput("t6_grant",     32'(o_grant),      32'd0);
    checkOutput("t6_valid",     32'(o_out_valid),  32'd0);
    checkOutput("t6_busy",      32'(o_busy),       32'd0);
    checkOutput("t6_cells",     32'(o_cell_count), 32'd0);
    resetDut();
    queueCell(0);
    queueCell(1);
    applyStimulus();
    stepCycle();
    checkOutput("t6_regrant", 32'(o_grant), 32'b0001);
    drain(400);
    checkOutput("t6_cells_after", 32'(o_cell_count), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Backstop so the run can never hang.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
